// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: field widths,
// transmit FSM states and the header encoding.
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int BYTE_W = 8;

    // Port 3 does not exist on the 1x3 router.
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;
    localparam logic [BYTE_W-1:0] ERR_CNT_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        HEADER,
        PAYLOAD,
        PARITY,
        ERRWAIT
    } tx_state_t;

    // Header byte carries the payload length above the destination port.
    function automatic logic [BYTE_W-1:0] make_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer for router_pkt_tx: DEPTH x 8 register array,
// synchronous write, combinational read.
module router_tx_buf
    import router_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [DEPTH];

    // Store one payload byte per accepted beat.
    // NOTE: the array has no reset; every entry read is written first in the
    // same packet, and leaving it out keeps the array in plain flops/RAM.
    // NOTE: sequential state is always updated with <= so every flop samples
    // the pre-edge value regardless of statement order.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port. Buffers a whole payload,
// then sends header, payload and parity under the router's busy
// back-pressure, and counts packets the router flags with err.
// Optional feature: define ROUTER_PKT_TX_INJ_EN to add the cmd_inj port,
// which inverts bit 0 of the parity byte of that packet.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int DEPTH = 64
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_addr,
    input  logic [5:0]        cmd_len,
`ifdef ROUTER_PKT_TX_INJ_EN
    input  logic              cmd_inj,
`endif
    output logic              cmd_err,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              busy,
    input  logic              err,
    output logic              pkt_valid,
    output logic [7:0]        data_out,
    output logic              pkt_done,
    output logic [7:0]        err_cnt
);

    localparam int AW = $clog2(DEPTH);

    tx_state_t         state, next_state;

    logic [BYTE_W-1:0] header_q;
    logic [BYTE_W-1:0] parity_q;
    logic [BYTE_W-1:0] parity_byte;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  last_idx;
    logic [LEN_W-1:0]  wr_idx;
    logic [LEN_W-1:0]  rd_idx;
    logic [LEN_W-1:0]  rd_next;

    logic              ew_cnt;
    logic              err_seen;

    logic              cmd_fire;
    logic              cmd_bad;
    logic              s_fire;
    logic              last_wr;
    logic              last_rd;

    logic              pkt_valid_d;
    logic [BYTE_W-1:0] data_out_d;

    logic [AW-1:0]     buf_wr_addr;
    logic [AW-1:0]     buf_rd_addr;
    logic [BYTE_W-1:0] buf_rd_data;

`ifdef ROUTER_PKT_TX_INJ_EN
    logic              inj_q;
    assign parity_byte = parity_q ^ {{(BYTE_W-1){1'b0}}, inj_q};
`else
    assign parity_byte = parity_q;
`endif

    // Handshakes are decoded straight from the state.
    assign cmd_ready = (state == IDLE);
    assign s_ready   = (state == COLLECT);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign s_fire    = s_valid && s_ready;
    assign cmd_bad   = (cmd_addr == ADDR_INVALID) || (cmd_len == '0);

    // Length lives in the latched header; indices run 0..len-1.
    assign len_q    = header_q[BYTE_W-1:ADDR_W];
    assign last_idx = len_q - LEN_W'(1);
    assign last_wr  = (wr_idx == last_idx);
    assign last_rd  = (rd_idx == last_idx);
    assign rd_next  = rd_idx + LEN_W'(1);

    // The read port looks one byte ahead so the next data_out is ready
    // to be registered on the transfer edge.
    assign buf_wr_addr = AW'(wr_idx);
    assign buf_rd_addr = (state == PAYLOAD) ? AW'(rd_next) : '0;

    router_tx_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clock   (clock),
        .wr_en   (s_fire),
        .wr_addr (buf_wr_addr),
        .wr_data (s_data),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: collect the payload, then walk header/payload/parity
    // one transfer at a time, then a fixed two-cycle error window.
    // NOTE: next_state gets a default before the case so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_fire && !cmd_bad) begin
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (s_fire && last_wr) begin
                    next_state = HEADER;
                end
            end
            HEADER: begin
                if (!busy) begin
                    next_state = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!busy && last_rd) begin
                    next_state = PARITY;
                end
            end
            PARITY: begin
                if (!busy) begin
                    next_state = ERRWAIT;
                end
            end
            ERRWAIT: begin
                if (ew_cnt) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered router outputs; they hold while busy.
    always_comb begin
        pkt_valid_d = pkt_valid;
        data_out_d  = data_out;
        case (state)
            IDLE, ERRWAIT: begin
                pkt_valid_d = 1'b0;
                data_out_d  = '0;
            end
            COLLECT: begin
                if (s_fire && last_wr) begin
                    pkt_valid_d = 1'b1;
                    data_out_d  = header_q;
                end
            end
            HEADER: begin
                if (!busy) begin
                    data_out_d = buf_rd_data;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    if (last_rd) begin
                        pkt_valid_d = 1'b0;
                        data_out_d  = parity_byte;
                    end else begin
                        data_out_d  = buf_rd_data;
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    data_out_d = '0;
                end
            end
            default: begin
                pkt_valid_d = 1'b0;
                data_out_d  = '0;
            end
        endcase
    end

    // Router-facing output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            pkt_valid <= pkt_valid_d;
            data_out  <= data_out_d;
        end
    end

    // Command latch, parity accumulation and buffer indices.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            header_q <= '0;
            parity_q <= '0;
            wr_idx   <= '0;
            rd_idx   <= '0;
`ifdef ROUTER_PKT_TX_INJ_EN
            inj_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        header_q <= make_header(cmd_len, cmd_addr);
                        parity_q <= make_header(cmd_len, cmd_addr);
                        wr_idx   <= '0;
`ifdef ROUTER_PKT_TX_INJ_EN
                        inj_q    <= cmd_inj;
`endif
                    end
                end
                COLLECT: begin
                    if (s_fire) begin
                        parity_q <= parity_q ^ s_data;
                        if (last_wr) begin
                            wr_idx <= '0;
                            rd_idx <= '0;
                        end else begin
                            wr_idx <= wr_idx + LEN_W'(1);
                        end
                    end
                end
                PAYLOAD: begin
                    if (!busy && !last_rd) begin
                        rd_idx <= rd_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status pulses and the error window: err in either ERRWAIT cycle
    // counts the packet once, saturating at 255.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_err  <= 1'b0;
            pkt_done <= 1'b0;
            ew_cnt   <= 1'b0;
            err_seen <= 1'b0;
            err_cnt  <= '0;
        end else begin
            cmd_err  <= cmd_fire && cmd_bad;
            pkt_done <= 1'b0;
            if (state == ERRWAIT) begin
                if (ew_cnt) begin
                    ew_cnt   <= 1'b0;
                    err_seen <= 1'b0;
                    pkt_done <= 1'b1;
                    if ((err_seen || err) && (err_cnt != ERR_CNT_MAX)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end else begin
                    ew_cnt   <= 1'b1;
                    err_seen <= err;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: a cycle table for the basic,
// back-pressured and rejected packets, then hand-written sequences for
// error-count saturation, reset mid-payload, a maximum-length packet and
// (with ROUTER_PKT_TX_INJ_EN) parity injection.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
`ifdef ROUTER_PKT_TX_INJ_EN
    logic       cmd_inj;
`endif
    logic       cmd_err;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       busy;
    logic       err;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       pkt_done;
    logic [7:0] err_cnt;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_cnt = 0;
    logic [7:0] pl [64];
    logic [7:0] last_parity;

    router_pkt_tx #(.DEPTH(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
`ifdef ROUTER_PKT_TX_INJ_EN
        .cmd_inj   (cmd_inj),
`endif
        .cmd_err   (cmd_err),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .busy      (busy),
        .err       (err),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .pkt_done  (pkt_done),
        .err_cnt   (err_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic       cv;
        logic [1:0] addr;
        logic [5:0] len;
        logic       sv;
        logic [7:0] sd;
        logic       bsy;
        logic       er;
        logic       pv;
        logic [7:0] dout;
        logic       cr;
        logic       sr;
        logic       done;
        logic       cerr;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t mk(
        input logic cv, input logic [1:0] addr, input logic [5:0] len,
        input logic sv, input logic [7:0] sd, input logic bsy, input logic er,
        input logic pv, input logic [7:0] dout, input logic cr, input logic sr,
        input logic done, input logic cerr, input logic [7:0] ecnt
    );
        vec_t v;
        v.cv = cv;   v.addr = addr; v.len = len;  v.sv = sv; v.sd = sd;
        v.bsy = bsy; v.er = er;     v.pv = pv;    v.dout = dout;
        v.cr = cr;   v.sr = sr;     v.done = done; v.cerr = cerr; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Command handshake followed by the payload from pl[0..n-1].
    task automatic start_packet(input logic [1:0] a, input logic [5:0] n);
        int guard = 0;
        int idx = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = n;
        while (!cmd_ready && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        cmd_valid = 1'b0;
        s_valid   = 1'b1;
        while (idx < int'(n) && guard < 400) begin
            s_data = pl[idx];
            if (s_ready) idx++;
            tick();
            guard++;
        end
        s_valid = 1'b0;
        check("payload accepted", idx, n);
    endtask

    // Full packet: send, then check every router-side cycle against the
    // expected header/payload/parity stream and the error window.
    task automatic send_packet(input logic [1:0] a, input logic [5:0] n, input logic inj,
                               input bit rnd_busy, input bit drive_err);
        logic [7:0] exp_s [66];
        logic [7:0] par;
        int k = 0;
        int guard = 0;
`ifdef ROUTER_PKT_TX_INJ_EN
        cmd_inj = inj;
`endif
        exp_s[0] = {n, a};
        par = {n, a};
        for (int i = 0; i < int'(n); i++) begin
            exp_s[i+1] = pl[i];
            par = par ^ pl[i];
        end
        par = par ^ {7'b0, inj};
        exp_s[n+1] = par;

        start_packet(a, n);
        while (k < int'(n) + 2 && guard < 1000) begin
            check($sformatf("stream byte %0d data_out", k), data_out, exp_s[k]);
            check($sformatf("stream byte %0d pkt_valid", k), pkt_valid, (k <= int'(n)));
            busy = rnd_busy && ($urandom_range(0, 2) == 0);
            if (!busy) begin
                if (k == int'(n) + 1) last_parity = data_out;
                k++;
            end
            tick();
            guard++;
        end
        busy = 1'b0;
        check("stream length", k, n + 2);

        // ERRWAIT cycle 1, then cycle 2 with the optional err.
        check("errwait data_out", data_out, 8'h00);
        tick();
        err = drive_err;
        tick();
        err = 1'b0;
        if (drive_err && exp_cnt < 255) exp_cnt++;
        check("pkt_done pulse", pkt_done, 1'b1);
        check("err_cnt", err_cnt, exp_cnt);
        tick();
        check("pkt_done cleared", pkt_done, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
`ifdef ROUTER_PKT_TX_INJ_EN
        cmd_inj   = 1'b0;
`endif
        s_valid   = 1'b0;
        s_data    = '0;
        busy      = 1'b0;
        err       = 1'b0;
        last_parity = '0;

        // Reset values.
        #12;
        check("reset pkt_valid", pkt_valid, 1'b0);
        check("reset data_out", data_out, 8'h00);
        check("reset cmd_err", cmd_err, 1'b0);
        check("reset pkt_done", pkt_done, 1'b0);
        check("reset s_ready", s_ready, 1'b0);
        check("reset err_cnt", err_cnt, 8'h00);
        check("reset cmd_ready", cmd_ready, 1'b1);
        #10;
        reset = 1'b0;
        tick();

        //          cv a  len sv sd     bsy er | pv dout   cr sr dn ce ecnt
        // Basic packet addr 1 len 3: A5 3C FF (err in HEADER must be ignored).
        vt.push_back(mk(1, 1, 3, 0, 8'h00, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 8'hA5, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 8'h3C, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 8'hFF, 0, 0,  1, 8'h0D, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1,  1, 8'hA5, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  1, 8'h3C, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  1, 8'hFF, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  0, 8'h6B, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 1, 0, 0, 0, 0));
        // Same packet, busy for 3 cycles on 3C and 1 cycle on parity, err in ERRWAIT.
        vt.push_back(mk(1, 1, 3, 0, 8'h00, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 8'hA5, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 8'h3C, 0, 0,  0, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 8'hFF, 0, 0,  1, 8'h0D, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  1, 8'hA5, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  1, 8'h3C, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0,  1, 8'h3C, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0,  1, 8'h3C, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0,  1, 8'h3C, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  1, 8'hFF, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  0, 8'h6B, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0,  0, 8'h6B, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 1, 0, 1, 0, 1));
        // Rejected commands: addr 3 / len 5, then addr 0 / len 0.
        vt.push_back(mk(1, 3, 5, 0, 8'h00, 0, 0,  0, 8'h00, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 1, 8'h55, 0, 0,  0, 8'h00, 1, 0, 0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 1, 8'h55, 0, 0,  0, 8'h00, 1, 0, 0, 0, 1));

        foreach (vt[i]) begin
            cmd_valid = vt[i].cv;
            cmd_addr  = vt[i].addr;
            cmd_len   = vt[i].len;
            s_valid   = vt[i].sv;
            s_data    = vt[i].sd;
            busy      = vt[i].bsy;
            err       = vt[i].er;
            tick();
            check($sformatf("v%0d pkt_valid", i), pkt_valid, vt[i].pv);
            check($sformatf("v%0d data_out", i), data_out, vt[i].dout);
            check($sformatf("v%0d cmd_ready", i), cmd_ready, vt[i].cr);
            check($sformatf("v%0d s_ready", i), s_ready, vt[i].sr);
            check($sformatf("v%0d pkt_done", i), pkt_done, vt[i].done);
            check($sformatf("v%0d cmd_err", i), cmd_err, vt[i].cerr);
            check($sformatf("v%0d err_cnt", i), err_cnt, vt[i].ecnt);
        end
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
        exp_cnt   = 1;
        tick();

        // Maximum-length packet to port 2 under random back-pressure.
        for (int i = 0; i < 63; i++) pl[i] = 8'($urandom);
        send_packet(2'd2, 6'd63, 1'b0, 1'b1, 1'b0);

        // 256 flagged packets: err_cnt climbs from 1 and saturates at 255.
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 4; i++) pl[i] = 8'($urandom);
            send_packet(2'($urandom_range(0, 2)), 6'($urandom_range(1, 4)), 1'b0, 1'b1, 1'b1);
            if (p == 199) check("err_cnt after 200 flagged", err_cnt, 8'd201);
        end
        check("err_cnt saturated", err_cnt, 8'd255);

        // Reset in the middle of a len-10 payload.
        for (int i = 0; i < 10; i++) pl[i] = 8'(8'h10 + i);
        start_packet(2'd2, 6'd10);
        check("mid header pkt_valid", pkt_valid, 1'b1);
        tick();
        tick();
        tick();
        check("mid payload data_out", data_out, 8'h12);
        #2;
        reset = 1'b1;
        #1;
        check("async reset pkt_valid", pkt_valid, 1'b0);
        check("async reset data_out", data_out, 8'h00);
        check("async reset cmd_ready", cmd_ready, 1'b1);
        check("async reset s_ready", s_ready, 1'b0);
        check("async reset err_cnt", err_cnt, 8'h00);
        exp_cnt = 0;
        #3;
        reset = 1'b0;
        tick();

        // Next packet after reset goes out intact.
        pl[0] = 8'hA5;
        pl[1] = 8'h3C;
        pl[2] = 8'hFF;
        send_packet(2'd1, 6'd3, 1'b0, 1'b0, 1'b0);
        check("post-reset parity", last_parity, 8'h6B);

`ifdef ROUTER_PKT_TX_INJ_EN
        // Corrupted parity on request.
        send_packet(2'd1, 6'd3, 1'b1, 1'b0, 1'b0);
        check("injected parity", last_parity, 8'h6A);
        send_packet(2'd1, 6'd3, 1'b0, 1'b0, 1'b0);
        check("parity after injection", last_parity, 8'h6B);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
